// File: rtl/random_generator.sv
// Range-constrained pseudo-random source.
// A Galois LFSR, seeded from in_seed, advances on every enabled cycle. The low byte of
// the new LFSR state is scaled into the signed inclusive range [in_min, in_max] and
// registered onto out_random, so a new value appears one cycle after the enable.

module random_generator #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           LFSR_WIDTH = 2 * DATA_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 16'hB400
) (
    input  logic                         in_clock,
    input  logic                         in_reset,
    input  logic                         in_enable,
    input  logic signed [DATA_WIDTH-1:0] in_min,
    input  logic signed [DATA_WIDTH-1:0] in_max,
    input  logic        [DATA_WIDTH-1:0] in_seed,
    output logic signed [DATA_WIDTH-1:0] out_random
);

    // Range arithmetic needs two guard bits: max - min + 1 spans up to 2^DATA_WIDTH.
    localparam int unsigned RW = DATA_WIDTH + 2;
    // Product of a DATA_WIDTH-bit sample and a (DATA_WIDTH+1)-bit range.
    localparam int unsigned PW = 2 * DATA_WIDTH + 1;

    logic        [LFSR_WIDTH-1:0] lfsr_q;
    logic        [LFSR_WIDTH-1:0] lfsr_step;
    logic        [LFSR_WIDTH-1:0] seed_state;

    logic signed [RW-1:0]         min_ext;
    logic signed [RW-1:0]         max_ext;
    logic signed [RW-1:0]         range_ext;
    logic                         range_valid;
    logic        [DATA_WIDTH:0]   range_mag;
    logic        [PW-1:0]         product;
    logic        [DATA_WIDTH:0]   offset;
    logic signed [RW-1:0]         sum_ext;
    logic        [DATA_WIDTH-1:0] mapped;

    // Bits that are structurally dropped by the scaling datapath.
    logic                         unused_bits;

    // Next LFSR state and the reset image of the seed.
    always_comb begin
        lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        // {seed, ~seed} always has at least one set bit, so the LFSR can never lock at zero.
        seed_state = {in_seed, ~in_seed};
    end

    // Range size and validity, in sign-extended arithmetic.
    always_comb begin
        min_ext     = {{(RW - DATA_WIDTH){in_min[DATA_WIDTH-1]}}, in_min};
        max_ext     = {{(RW - DATA_WIDTH){in_max[DATA_WIDTH-1]}}, in_max};
        range_ext   = max_ext - min_ext + RW'(1);
        range_valid = (min_ext <= max_ext);
        // For a valid range this is 1..2^DATA_WIDTH and fits unsigned in DATA_WIDTH+1 bits.
        range_mag   = range_ext[DATA_WIDTH:0];
    end

    // Scale the new LFSR low byte into [in_min, in_max]: offset = (r * range) >> DATA_WIDTH.
    always_comb begin
        product = PW'(lfsr_step[DATA_WIDTH-1:0]) * PW'(range_mag);
        offset  = product[PW-1:DATA_WIDTH];
        sum_ext = min_ext + $signed({1'b0, offset});
        // An inverted range pins the output to the lower bound.
        mapped  = range_valid ? sum_ext[DATA_WIDTH-1:0] : in_min;
    end

    assign unused_bits = ^{range_ext[RW-1], product[DATA_WIDTH-1:0], sum_ext[RW-1:DATA_WIDTH]};

    // State update: reset loads the seed and the lower bound; enable steps and samples.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            lfsr_q     <= seed_state;
            out_random <= in_min;
        end else if (in_enable) begin
            lfsr_q     <= lfsr_step;
            out_random <= mapped;
        end
    end

endmodule

// File: tb/tb_random_generator.sv
// Directed self-checking bench for random_generator.
module tb_random_generator;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic signed [7:0] mn;
    logic signed [7:0] mx;
    logic        [7:0] seed;
    logic signed [7:0] out;

    int checks   = 0;
    int failures = 0;

    // Reference LFSR state tracked by the bench.
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    random_generator dut (
        .in_clock  (clk),
        .in_reset  (rst),
        .in_enable (en),
        .in_min    (mn),
        .in_max    (mx),
        .in_seed   (seed),
        .out_random(out)
    );

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int ref_map(input int r, input int lo, input int hi);
        if (lo > hi) return lo;
        return lo + (r * (hi - lo + 1)) / 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [7:0] s, input int lo, input int hi, input int cycles);
        seed = s;
        mn   = 8'(lo);
        mx   = 8'(hi);
        en   = 1'b0;
        rst  = 1'b1;
        repeat (cycles) tick();
        rst    = 1'b0;
        m_lfsr = {s, ~s};
    endtask

    task automatic test_reset();
        apply_reset(8'd1, 0, 5, 2);
        checks++;
        if (out !== 8'sd0) begin
            failures++;
            $display("FAIL reset_out actual=%0d expected=0", out);
        end
        checks++;
        if (dut.lfsr_q !== 16'h01FE) begin
            failures++;
            $display("FAIL reset_lfsr actual=%h expected=01fe", dut.lfsr_q);
        end
    endtask

    task automatic test_sequence();
        int          exp_out [3] = '{5, 2, 1};
        logic [15:0] exp_lfsr[3] = '{16'h00FF, 16'hB47F, 16'hEE3F};
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== 8'(exp_out[i])) begin
                failures++;
                $display("FAIL seq_out[%0d] actual=%0d expected=%0d", i, out, exp_out[i]);
            end
            checks++;
            if (dut.lfsr_q !== exp_lfsr[i]) begin
                failures++;
                $display("FAIL seq_lfsr[%0d] actual=%h expected=%h", i, dut.lfsr_q, exp_lfsr[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out !== 8'sd1 || dut.lfsr_q !== 16'hEE3F) begin
                failures++;
                $display("FAIL hold[%0d] actual out=%0d lfsr=%h expected out=1 lfsr=ee3f",
                         i, out, dut.lfsr_q);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        // 0xEE3F -> 0xC31F, low byte 31, 31*6>>8 = 0
        if (out !== 8'sd0 || dut.lfsr_q !== 16'hC31F) begin
            failures++;
            $display("FAIL resume actual out=%0d lfsr=%h expected out=0 lfsr=c31f",
                     out, dut.lfsr_q);
        end
        en = 1'b0;
    endtask

    task automatic test_range_sweep(input int lo, input int hi);
        bit hit[256];
        int misses;
        int exp;
        for (int i = 0; i < 256; i++) hit[i] = 1'b0;
        apply_reset(8'h5A, lo, hi, 1);
        en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            m_lfsr = ref_step(m_lfsr);
            exp    = ref_map(int'(m_lfsr[7:0]), lo, hi);
            checks++;
            if (out !== 8'(exp) || int'(out) < lo || int'(out) > hi) begin
                failures++;
                $display("FAIL sweep(%0d,%0d)[%0d] actual=%0d expected=%0d", lo, hi, i, out, exp);
            end
            if (int'(out) >= lo && int'(out) <= hi) hit[int'(out) - lo] = 1'b1;
        end
        misses = 0;
        for (int v = 0; v <= hi - lo; v++) if (!hit[v]) misses++;
        checks++;
        if (misses != 0) begin
            failures++;
            $display("FAIL sweep_cover(%0d,%0d) actual_missing=%0d expected_missing=0",
                     lo, hi, misses);
        end
        en = 1'b0;
    endtask

    task automatic test_edge_ranges();
        int exp;
        // Degenerate range
        apply_reset(8'h33, -7, -7, 1);
        en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (out !== -8'sd7) begin
                failures++;
                $display("FAIL degenerate[%0d] actual=%0d expected=-7", i, out);
            end
        end
        // Full range: out = low byte - 128
        apply_reset(8'hC4, -128, 127, 1);
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            m_lfsr = ref_step(m_lfsr);
            exp    = int'(m_lfsr[7:0]) - 128;
            checks++;
            if (out !== 8'(exp)) begin
                failures++;
                $display("FAIL full_range[%0d] actual=%0d expected=%0d", i, out, exp);
            end
        end
        // Inverted range: out pinned to min while the LFSR keeps stepping
        apply_reset(8'h07, 10, 3, 1);
        en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            m_lfsr = ref_step(m_lfsr);
            checks++;
            if (out !== 8'sd10 || dut.lfsr_q !== m_lfsr) begin
                failures++;
                $display("FAIL inverted[%0d] actual out=%0d lfsr=%h expected out=10 lfsr=%h",
                         i, out, dut.lfsr_q, m_lfsr);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_seed_zero();
        int exp;
        apply_reset(8'h00, -50, 50, 1);
        checks++;
        if (dut.lfsr_q !== 16'h00FF) begin
            failures++;
            $display("FAIL seed0_lfsr actual=%h expected=00ff", dut.lfsr_q);
        end
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            m_lfsr = ref_step(m_lfsr);
            exp    = ref_map(int'(m_lfsr[7:0]), -50, 50);
            checks++;
            if (out !== 8'(exp) || dut.lfsr_q !== m_lfsr) begin
                failures++;
                $display("FAIL seed0_run[%0d] actual out=%0d lfsr=%h expected out=%0d lfsr=%h",
                         i, out, dut.lfsr_q, exp, m_lfsr);
            end
        end
    endtask

    task automatic test_reset_priority();
        // en is still 1 from the previous run
        seed = 8'd1;
        mn   = -8'sd3;
        mx   = 8'sd4;
        rst  = 1'b1;
        tick();
        checks++;
        if (out !== -8'sd3 || dut.lfsr_q !== 16'h01FE) begin
            failures++;
            $display("FAIL reset_priority actual out=%0d lfsr=%h expected out=-3 lfsr=01fe",
                     out, dut.lfsr_q);
        end
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_reproducibility();
        int exp_out[3] = '{5, 2, 1};
        apply_reset(8'd1, 0, 5, 1);
        en = 1'b1;
        repeat (7) tick();
        // Mid-stream reset with the same seed restarts the sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== 8'(exp_out[i])) begin
                failures++;
                $display("FAIL repro[%0d] actual=%0d expected=%0d", i, out, exp_out[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mn   = '0;
        mx   = '0;
        seed = '0;
        test_reset();
        test_sequence();
        test_enable_gating();
        test_range_sweep(-20, -10);
        test_range_sweep(-20, 2);
        test_range_sweep(20, 26);
        test_range_sweep(-20, 0);
        test_range_sweep(0, 5);
        test_edge_ranges();
        test_seed_zero();
        test_reset_priority();
        test_reproducibility();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
